mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 109 ++++++++++
 tb/tb_mem_arbiter.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and data access.
// Ports: clk_i/rst_i; if_* fetch side; dm_* data side; mem_* memory; stall_o.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_STREAK = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ready_o,
  output logic [DATA_W-1:0] if_data_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_ready_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stall_o
);

  typedef enum logic [1:0] {
    IDLE,
    IF_BUSY,
    DM_BUSY,
    RESP
  } state_t;

  localparam logic [2:0] STREAK_MAX = 3'(MAX_STREAK);

  state_t     state;
  logic [2:0] streak;
  logic       dm_win;

  // Data wins unless it has already starved a waiting fetch long enough.
  assign dm_win = dm_req_i && !(if_req_i && streak == STREAK_MAX);

  assign stall_o = (if_req_i & ~if_ready_o) | (dm_req_i & ~dm_ready_o);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      streak      <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      if_ready_o  <= 1'b0;
      dm_ready_o  <= 1'b0;
      if_data_o   <= '0;
      dm_rdata_o  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (dm_win) begin
            state       <= DM_BUSY;
            mem_req_o   <= 1'b1;
            mem_we_o    <= dm_we_i;
            mem_addr_o  <= dm_addr_i;
            mem_wdata_o <= dm_wdata_i;
            if (!if_req_i)
              streak <= '0;
            else if (streak != STREAK_MAX)
              streak <= streak + 3'd1;
          end else if (if_req_i) begin
            state       <= IF_BUSY;
            mem_req_o   <= 1'b1;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= if_addr_i;
            mem_wdata_o <= '0;
            streak      <= '0;
          end
        end
        IF_BUSY: begin
          if (mem_ack_i) begin
            state      <= RESP;
            mem_req_o  <= 1'b0;
            if_data_o  <= mem_rdata_i;
            if_ready_o <= 1'b1;
          end
        end
        DM_BUSY: begin
          if (mem_ack_i) begin
            state      <= RESP;
            mem_req_o  <= 1'b0;
            dm_ready_o <= 1'b1;
            // A write returns nothing; keep the last read value.
            if (!mem_we_o)
              dm_rdata_o <= mem_rdata_i;
          end
        end
        RESP: begin
          state      <= IDLE;
          if_ready_o <= 1'b0;
          dm_ready_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: memory model with programmable ack latency,
// expected responses queued at stimulus time and popped on ready pulses.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_ready_o;
  logic [31:0] if_data_o;
  logic        dm_req_i;
  logic        dm_we_i;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_wdata_i;
  logic        dm_ready_o;
  logic [31:0] dm_rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        stall_o;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_STREAK(4)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i),
    .if_ready_o(if_ready_o), .if_data_o(if_data_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i),
    .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
    .dm_ready_o(dm_ready_o), .dm_rdata_o(dm_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .stall_o(stall_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct packed {
    logic        dm;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] last_if = '0;
  logic [31:0] last_dm = '0;

  // memory model
  int          lat = 0;
  int          cnt = 0;
  logic        spur = 1'b0;
  logic [255:0] wr_valid;
  logic [31:0] wr_data[256];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (wr_valid[a[9:2]])
      return wr_data[a[9:2]];
    case (a[9:2])
      8'd16:   return 32'h2008000A;
      8'd64:   return 32'h11223344;
      default: return {4{a[9:2]}};
    endcase
  endfunction

  always @(negedge clk) begin
    mem_ack_i   <= (mem_req_o && cnt == lat) || spur;
    mem_rdata_i <= spur ? 32'hBAD0BAD0 : mem_rd(mem_addr_o);
  end

  always @(posedge clk) begin
    if (mem_req_o && !mem_ack_i)
      cnt <= cnt + 1;
    else
      cnt <= 0;
    if (rst_i)
      wr_valid <= '0;
    else if (mem_req_o && mem_ack_i && mem_we_o) begin
      wr_valid[mem_addr_o[9:2]] <= 1'b1;
      wr_data[mem_addr_o[9:2]]  <= mem_wdata_o;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick();
    tick();
    @(negedge clk);
    n_checks++;
    if ({mem_req_o, mem_we_o, if_ready_o, dm_ready_o} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 0000",
               {mem_req_o, mem_we_o, if_ready_o, dm_ready_o});
    end
    n_checks++;
    if (mem_addr_o !== 32'h0 || mem_wdata_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mem: got %h/%h expected 0/0",
               mem_addr_o, mem_wdata_o);
    end
    n_checks++;
    if (if_data_o !== 32'h0 || dm_rdata_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h/%h expected 0/0",
               if_data_o, dm_rdata_o);
    end
    n_checks++;
    if (stall_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_stall: got %b expected 0", stall_o);
    end
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_fetch();
    exp_t e;
    bit   seen = 0;
    lat = 2;
    tick();
    if_req_i  = 1'b1;
    if_addr_i = 32'h40;
    e.dm   = 1'b0;
    e.data = mem_rd(32'h40);
    exp_q.push_back(e);
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (k == 0) begin
        n_checks++;
        if (stall_o !== 1'b1) begin
          n_fail++;
          $display("FAIL fetch_stall: got %b expected 1", stall_o);
        end
      end
      if (k == 1) begin
        n_checks++;
        if (mem_req_o !== 1'b1 || mem_we_o !== 1'b0 ||
            mem_addr_o !== 32'h40) begin
          n_fail++;
          $display("FAIL fetch_mem: got req=%b we=%b a=%h expected 1 0 40",
                   mem_req_o, mem_we_o, mem_addr_o);
        end
      end
      if (if_ready_o || dm_ready_o) begin
        seen = 1;
        e = exp_q.pop_front();
        n_checks++;
        if (dm_ready_o !== 1'b0 || if_data_o !== e.data) begin
          n_fail++;
          $display("FAIL fetch_data: got %h dm=%b expected %h",
                   if_data_o, dm_ready_o, e.data);
        end
        n_checks++;
        if (k != 2 + lat || stall_o !== 1'b0) begin
          n_fail++;
          $display("FAIL fetch_latency: got %0d stall=%b expected %0d 0",
                   k, stall_o, 2 + lat);
        end
        last_if = e.data;
      end
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL fetch_timeout: got no if_ready_o expected pulse");
    end
    tick();
    if_req_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (if_ready_o !== 1'b0 || if_data_o !== last_if) begin
      n_fail++;
      $display("FAIL fetch_pulse: got rdy=%b d=%h expected 0 %h",
               if_ready_o, if_data_o, last_if);
    end
  endtask

  task automatic test_simultaneous();
    exp_t e;
    bit   done = 0;
    bit   stall_bad = 0;
    bit   drop = 0;
    lat = 1;
    tick();
    if_req_i  = 1'b1;
    if_addr_i = 32'h40;
    dm_req_i  = 1'b1;
    dm_we_i   = 1'b0;
    dm_addr_i = 32'h100;
    e.dm = 1'b1; e.data = mem_rd(32'h100); exp_q.push_back(e);
    e.dm = 1'b0; e.data = mem_rd(32'h40);  exp_q.push_back(e);
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      drop = 0;
      if (if_ready_o || dm_ready_o) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL simul_extra: got pulse if=%b dm=%b expected none",
                   if_ready_o, dm_ready_o);
        end else begin
          e = exp_q.pop_front();
          if (dm_ready_o !== e.dm || if_ready_o !== !e.dm ||
              (e.dm ? dm_rdata_o : if_data_o) !== e.data) begin
            n_fail++;
            $display("FAIL simul_order: got dm=%b if=%b %h/%h expected dm=%b %h",
                     dm_ready_o, if_ready_o, dm_rdata_o, if_data_o,
                     e.dm, e.data);
          end
          if (e.dm) begin
            last_dm = e.data;
            drop = 1;
          end else begin
            last_if = e.data;
            done = 1;
          end
        end
      end
      if (stall_o !== !done)
        stall_bad = 1;
      if (drop) begin
        tick();
        dm_req_i = 1'b0;
      end
    end
    n_checks++;
    if (!done || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL simul_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
    n_checks++;
    if (stall_bad) begin
      n_fail++;
      $display("FAIL simul_stall: got wrong stall_o expected 1 until last ready");
    end
    tick();
    if_req_i = 1'b0;
    dm_req_i = 1'b0;
  endtask

  task automatic test_starvation();
    exp_t e;
    for (int rep = 0; rep < 2; rep++) begin
      bit done = 0;
      lat = rep;
      tick();
      if_req_i  = 1'b1;
      if_addr_i = 32'h40;
      dm_req_i  = 1'b1;
      dm_we_i   = 1'b0;
      dm_addr_i = rep == 0 ? 32'h100 : 32'h200;
      for (int g = 0; g < 4; g++) begin
        e.dm = 1'b1; e.data = mem_rd(dm_addr_i); exp_q.push_back(e);
      end
      e.dm = 1'b0; e.data = mem_rd(32'h40); exp_q.push_back(e);
      for (int k = 0; k < 60 && !done; k++) begin
        @(negedge clk);
        if (if_ready_o || dm_ready_o) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL starve_extra: got pulse expected none");
          end else begin
            e = exp_q.pop_front();
            if (dm_ready_o !== e.dm || if_ready_o !== !e.dm ||
                (e.dm ? dm_rdata_o : if_data_o) !== e.data) begin
              n_fail++;
              $display("FAIL starve_order: rep %0d got dm=%b if=%b expected dm=%b (%0d left)",
                       rep, dm_ready_o, if_ready_o, e.dm, exp_q.size());
            end
            if (e.dm)
              last_dm = e.data;
            else begin
              last_if = e.data;
              done = 1;
            end
          end
        end
      end
      n_checks++;
      if (!done || exp_q.size() != 0) begin
        n_fail++;
        $display("FAIL starve_timeout: rep %0d got %0d pending expected 0",
                 rep, exp_q.size());
        exp_q.delete();
      end
      tick();
      if_req_i = 1'b0;
      dm_req_i = 1'b0;
    end
  endtask

  task automatic test_write();
    exp_t e;
    lat = 0;
    for (int pass = 0; pass < 2; pass++) begin
      bit seen = 0;
      tick();
      dm_req_i   = 1'b1;
      dm_we_i    = pass == 0;
      dm_addr_i  = 32'h8;
      dm_wdata_i = 32'hDEADBEEF;
      e.dm   = 1'b1;
      e.data = pass == 0 ? last_dm : 32'hDEADBEEF;
      exp_q.push_back(e);
      for (int k = 0; k < 10 && !seen; k++) begin
        @(negedge clk);
        if (k == 1) begin
          n_checks++;
          if (mem_req_o !== 1'b1 || mem_we_o !== dm_we_i ||
              mem_addr_o !== 32'h8 ||
              (dm_we_i && mem_wdata_o !== 32'hDEADBEEF)) begin
            n_fail++;
            $display("FAIL write_mem: pass %0d got req=%b we=%b a=%h d=%h",
                     pass, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o);
          end
        end
        if (if_ready_o || dm_ready_o) begin
          seen = 1;
          e = exp_q.pop_front();
          n_checks++;
          if (dm_ready_o !== 1'b1 || dm_rdata_o !== e.data || k != 2) begin
            n_fail++;
            $display("FAIL write_resp: pass %0d got %h at %0d expected %h at 2",
                     pass, dm_rdata_o, k, e.data);
          end
          last_dm = e.data;
        end
      end
      if (!seen) begin
        n_checks++;
        n_fail++;
        $display("FAIL write_timeout: got no dm_ready_o expected pulse");
        exp_q.delete();
      end
      tick();
      dm_req_i = 1'b0;
      dm_we_i  = 1'b0;
    end
  endtask

  task automatic test_spurious();
    tick();
    spur = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_checks++;
      if (if_ready_o !== 1'b0 || dm_ready_o !== 1'b0 ||
          mem_req_o !== 1'b0 || if_data_o !== last_if ||
          dm_rdata_o !== last_dm) begin
        n_fail++;
        $display("FAIL spurious_ack: cyc %0d got %b%b%b %h/%h expected 000 %h/%h",
                 k, if_ready_o, dm_ready_o, mem_req_o, if_data_o,
                 dm_rdata_o, last_if, last_dm);
      end
      if (k == 1) begin
        tick();
        spur = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid();
    bit busy = 0;
    lat = 6;
    tick();
    dm_req_i  = 1'b1;
    dm_we_i   = 1'b0;
    dm_addr_i = 32'h100;
    for (int k = 0; k < 5 && !busy; k++) begin
      @(negedge clk);
      busy = mem_req_o;
    end
    n_checks++;
    if (!busy) begin
      n_fail++;
      $display("FAIL rstmid_grant: got mem_req_o=0 expected 1");
    end
    tick();
    rst_i    = 1'b1;
    dm_req_i = 1'b0;
    tick();
    rst_i = 1'b0;
    spur  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++;
      if (dm_ready_o !== 1'b0 || if_ready_o !== 1'b0 ||
          mem_req_o !== 1'b0 || dm_rdata_o !== 32'h0) begin
        n_fail++;
        $display("FAIL rstmid_ack: cyc %0d got rdy=%b%b req=%b d=%h expected 000 0",
                 k, dm_ready_o, if_ready_o, mem_req_o, dm_rdata_o);
      end
      if (k == 0) begin
        tick();
        spur = 1'b0;
      end
    end
  endtask

  initial begin
    rst_i      = 1'b1;
    if_req_i   = 1'b0;
    if_addr_i  = '0;
    dm_req_i   = 1'b0;
    dm_we_i    = 1'b0;
    dm_addr_i  = '0;
    dm_wdata_i = '0;
    test_reset();
    test_fetch();
    test_simultaneous();
    test_starvation();
    test_write();
    test_spurious();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
